tt_um_cla_pipe: RTL
===================

TT_UM_CLA_PIPE -- requirements
Module: tt_um_cla_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 8 in range 8..32.
REQ-002 Parameter GROUP, default 4, carry-lookahead group size in bits; SHALL divide WIDTH.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  design selected; when 0, all state SHALL hold.
REQ-006 ui_in  input  8  command/operand byte.
REQ-007 uio_in  input  8  [0]=in_valid, [1]=out_ack, [7:2] ignored.
REQ-008 uo_out  output  8  current result byte.
REQ-009 uio_out  output  8  [3:0]=0, [4]=out_valid, [5]=carry, [6]=overflow, [7]=busy.
REQ-010 uio_oe  output  8  constant 8'hF0.

Function
REQ-011 NB = WIDTH/8; byte transfers SHALL be LSB first.
REQ-012 States: IDLE, LOAD_A, LOAD_B, COMPUTE, SEND; busy=1 in every state except IDLE.
REQ-013 Byte accepted on a rising edge with ena=1, in_valid=1 and state IDLE/LOAD_A/LOAD_B; in_valid elsewhere SHALL be ignored.
REQ-014 IDLE accepts a command byte; ui_in[1:0] op: 00 ADD, 01 SUB, 10 ACC, 11 CLR; ui_in[7:2] ignored.
REQ-015 ADD/SUB: IDLE->LOAD_A; after NB bytes ->LOAD_B; after NB bytes ->COMPUTE.
REQ-016 ACC: IDLE->LOAD_B directly; operand A SHALL be the accumulator register.
REQ-017 CLR: accumulator <= 0, state stays IDLE, no output phase.
REQ-018 Byte counter SHALL reset to 0 on every state transition.
REQ-019 COMPUTE lasts exactly one cycle, then ->SEND; a new command is accepted no earlier than 2 cycles after the last B byte.
REQ-020 Adder: GROUP-bit lookahead blocks (generate/propagate per bit, group carries chained); result registered at COMPUTE exit.
REQ-021 ADD/ACC: R = A + B mod 2^WIDTH, carry = carry out of bit WIDTH-1.
REQ-022 SUB: R = A + ~B + 1; carry = 1 means no borrow (A >= B unsigned).
REQ-023 overflow = two's-complement signed overflow of the operation performed.
REQ-024 ACC: accumulator <= R on COMPUTE exit; ADD/SUB SHALL NOT modify accumulator.
REQ-025 SEND: out_valid=1, uo_out = result byte[idx]; each edge with out_ack=1 advances idx; after the NB-th ack ->IDLE, out_valid=0.
REQ-026 carry/overflow SHALL hold their last computed value until the next COMPUTE or reset.
REQ-027 Outside SEND, uo_out SHALL be 0.
REQ-028 ena=0 in any state: no transfer, no count advance, outputs unchanged.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, counter 0, accumulator 0, result 0, carry 0, overflow 0, out_valid 0, busy 0, uo_out 0, independent of clk.
REQ-030 Reset in any state, including mid-load or mid-SEND, SHALL discard the partial transaction; first command accepted on first valid edge after rst_n rises.

Verification (WIDTH=16, GROUP=4)
REQ-031 ADD, A=0x1234, B=0x0FCC -> bytes 0x00,0x22 (R=0x2200), carry 0, overflow 0, out_valid 1 cycle after COMPUTE.
REQ-032 ADD, A=0xFFFF, B=0x0001 -> R=0x0000, carry 1, overflow 0.
REQ-033 SUB, A=0x8000, B=0x0001 -> R=0x7FFF, carry 1, overflow 1; SUB 0x0001-0x0002 -> R=0xFFFF, carry 0.
REQ-034 CLR; ACC B=0x7000 -> R=0x7000; ACC B=0x7000 -> R=0xE000, overflow 1; intervening ADD leaves accumulator 0x7000.
REQ-035 ADD with ena=0 for 3 cycles after first A byte and in_valid held 1 -> no extra bytes consumed, result unchanged vs. ena=1 run.
REQ-036 rst_n=0 pulse after one B byte -> all outputs 0 asynchronously, busy 0; subsequent full ADD 0x0001+0x0001 -> R=0x0002.

Source files
------------

// File: rtl/tt_um_cla_pipe.sv
// Byte-serial carry-lookahead add/sub/accumulate unit.
// Operands stream in LSB first; the result streams out under ack.
module tt_um_cla_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NB = WIDTH / 8;
  localparam int NG = WIDTH / GROUP;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_SEND
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD, OP_SUB, OP_ACC, OP_CLR
  } op_t;

  state_t           r_st, w_nxt;
  op_t              r_op, w_cmd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_res;
  logic             r_carry, r_ovf;

  logic             w_in_v, w_ack, w_last, w_adv;
  logic [WIDTH-1:0] w_opa, w_opb, w_g, w_p, w_sum;
  logic [NG:0]      w_gc;
  logic             w_cin, w_ovf;
  logic             w_unused;

  assign w_in_v   = ena & uio_in[0];
  assign w_ack    = ena & uio_in[1];
  assign w_cmd    = op_t'(ui_in[1:0]);
  assign w_last   = (r_cnt == CW'(NB - 1));
  assign w_unused = &{1'b0, uio_in[7:2]};

  always_comb begin
    w_nxt = r_st;
    w_adv = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (w_in_v) begin
          unique case (w_cmd)
            OP_ADD, OP_SUB: w_nxt = S_LOAD_A;
            OP_ACC:         w_nxt = S_LOAD_B;
            default:        w_nxt = S_IDLE;
          endcase
        end
      end
      S_LOAD_A: begin
        w_adv = w_in_v;
        if (w_in_v && w_last) w_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_adv = w_in_v;
        if (w_in_v && w_last) w_nxt = S_COMPUTE;
      end
      S_COMPUTE: w_nxt = S_SEND;
      S_SEND: begin
        w_adv = w_ack;
        if (w_ack && w_last) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // SUB is A + ~B + 1; ACC takes A from the accumulator
  assign w_opa = (r_op == OP_ACC) ? r_acc : r_a;
  assign w_opb = (r_op == OP_SUB) ? ~r_b : r_b;
  assign w_cin = (r_op == OP_SUB);
  assign w_g   = w_opa & w_opb;
  assign w_p   = w_opa ^ w_opb;

  always_comb begin : cla
    logic gg, gp, c;
    w_gc    = '0;
    w_gc[0] = w_cin;
    w_sum   = '0;
    for (int g = 0; g < NG; g++) begin
      gg = 1'b0;
      gp = 1'b1;
      c  = w_gc[g];
      for (int i = 0; i < GROUP; i++) begin
        w_sum[g*GROUP+i] = w_p[g*GROUP+i] ^ c;
        c  = w_g[g*GROUP+i] | (w_p[g*GROUP+i] & c);
        gg = w_g[g*GROUP+i] | (w_p[g*GROUP+i] & gg);
        gp = gp & w_p[g*GROUP+i];
      end
      w_gc[g+1] = gg | (gp & w_gc[g]);
    end
  end

  assign w_ovf = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != w_opa[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= S_IDLE;
      r_op    <= OP_ADD;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (ena) begin
      r_st <= w_nxt;
      if (w_nxt != r_st) r_cnt <= '0;
      else if (w_adv)    r_cnt <= r_cnt + CW'(1);
      if (r_st == S_IDLE && w_in_v) begin
        r_op <= w_cmd;
        if (w_cmd == OP_CLR) r_acc <= '0;
      end
      if (r_st == S_LOAD_A && w_in_v) r_a[r_cnt*8 +: 8] <= ui_in;
      if (r_st == S_LOAD_B && w_in_v) r_b[r_cnt*8 +: 8] <= ui_in;
      if (r_st == S_COMPUTE) begin
        r_res   <= w_sum;
        r_carry <= w_gc[NG];
        r_ovf   <= w_ovf;
        if (r_op == OP_ACC) r_acc <= w_sum;
      end
    end
  end

  assign uo_out  = (r_st == S_SEND) ? r_res[r_cnt*8 +: 8] : 8'h00;
  assign uio_out = {(r_st != S_IDLE), r_ovf, r_carry,
                    (r_st == S_SEND), 4'h0};
  assign uio_oe  = 8'hF0;

endmodule
